// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stable period, then releases the downstream system reset.
// Optional statistics counters are built when PLL_RST_SEQ_STATS_EN is defined.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic [1:0] seq_state,
    output logic [7:0] lock_lost_cnt,
    output logic [7:0] timeout_cnt
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                      MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned STAT_W  = 8;

    // Down-counter reload values: each phase runs for (load + 1) edges.
    localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sync_meta;
    logic             r_sync;
    logic             w_locked_s;
    logic             r_pll_rst;
    logic             w_pll_rst_nxt;
    logic             r_sys_reset_n;
    logic             w_sys_reset_n_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_locked_s = r_sync;

    // Next-state, shared counter and next registered outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = TIMEOUT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = STABLE_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = PLL_RST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_STABLE: begin
                // A drop wins over completion on the same edge.
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = TIMEOUT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = PLL_RST_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = PLL_RST_LOAD;
            end
        endcase
        w_pll_rst_nxt     = (w_state_nxt == S_PLL_RST);
        w_sys_reset_n_nxt = (w_state_nxt == S_RUN);
    end

    // State, counter and registered reset outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= PLL_RST_LOAD;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pll_rst     <= w_pll_rst_nxt;
            r_sys_reset_n <= w_sys_reset_n_nxt;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_reset_n = r_sys_reset_n;
    assign seq_state   = r_state;

`ifdef PLL_RST_SEQ_STATS_EN
    logic              w_timeout;
    logic              w_lock_lost;
    logic [STAT_W-1:0] r_lock_lost_cnt;
    logic [STAT_W-1:0] r_timeout_cnt;

    assign w_timeout   = (r_state == S_WAIT_LOCK) && !w_locked_s && (r_cnt == '0);
    assign w_lock_lost = (r_state == S_RUN) && !w_locked_s;

    // Saturating event counters for lock timeouts and lock losses in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_lost_cnt <= '0;
            r_timeout_cnt   <= '0;
        end else begin
            if (w_lock_lost && (r_lock_lost_cnt != '1)) begin
                r_lock_lost_cnt <= r_lock_lost_cnt + STAT_W'(1);
            end
            if (w_timeout && (r_timeout_cnt != '1)) begin
                r_timeout_cnt <= r_timeout_cnt + STAT_W'(1);
            end
        end
    end

    assign lock_lost_cnt = r_lock_lost_cnt;
    assign timeout_cnt   = r_timeout_cnt;
`else
    assign lock_lost_cnt = STAT_W'(0);
    assign timeout_cnt   = STAT_W'(0);
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues the expected output
// transitions with their clock edge; a monitor checks every observed change.
module tb_pll_reset_sequencer;

`ifdef PLL_RST_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       pr;
        logic       sr;
        logic [1:0] st;
        logic [7:0] ll;
        logic [7:0] to;
    } snap_t;

    typedef struct {
        int    e;
        snap_t s;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic [1:0] seq_state;
    logic [7:0] lock_lost_cnt;
    logic [7:0] timeout_cnt;

    int    edge_n = 0;
    int    total  = 0;
    int    bad    = 0;
    int    ll_n   = 0;
    int    to_n   = 0;
    snap_t prev;
    ev_t   exp_q[$];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .seq_state     (seq_state),
        .lock_lost_cnt (lock_lost_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [7:0] cv(input int v);
        if (!STATS) return 8'd0;
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic snap_t mk(input logic pr, input logic sr, input logic [1:0] st);
        snap_t s;
        s.pr = pr;
        s.sr = sr;
        s.st = st;
        s.ll = cv(ll_n);
        s.to = cv(to_n);
        return s;
    endfunction

    function automatic snap_t cur_snap();
        snap_t s;
        s.pr = pll_rst;
        s.sr = sys_reset_n;
        s.st = seq_state;
        s.ll = lock_lost_cnt;
        s.to = timeout_cnt;
        return s;
    endfunction

    task automatic push(input int e, input logic pr, input logic sr, input logic [1:0] st);
        ev_t x;
        x.e = e;
        x.s = mk(pr, sr, st);
        exp_q.push_back(x);
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string nm, input snap_t e);
        snap_t c;
        c = cur_snap();
        total++;
        if (c != e) begin
            bad++;
            $display("FAIL %s got pr=%0d sr=%0d st=%0d ll=%0d to=%0d exp pr=%0d sr=%0d st=%0d ll=%0d to=%0d",
                     nm, c.pr, c.sr, c.st, c.ll, c.to, e.pr, e.sr, e.st, e.ll, e.to);
        end
    endtask

    // Release reset at a falling edge; PLL reset must last 4 edges.
    task automatic release_rst();
        int k;
        k = edge_n;
        reset_n = 1'b1;
        push(k + 4, 1'b0, 1'b0, 2'd1);
    endtask

    // Raise lock while in WAIT_LOCK: STABLE 3 edges later, RUN 11 edges later.
    task automatic raise_lock();
        int k;
        k = edge_n;
        pll_locked = 1'b1;
        push(k + 3,  1'b0, 1'b0, 2'd2);
        push(k + 11, 1'b0, 1'b1, 2'd3);
    endtask

    // Drop lock while in RUN: PLL reset 3 edges later, WAIT_LOCK 4 edges after that.
    task automatic drop_in_run();
        int k;
        k = edge_n;
        pll_locked = 1'b0;
        ll_n++;
        push(k + 3, 1'b1, 1'b0, 2'd0);
        push(k + 7, 1'b0, 1'b0, 2'd1);
        nxt(8);
    endtask

    // Asynchronous reset asserted between clock edges, then released.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        ll_n = 0;
        to_n = 0;
        push(edge_n, 1'b1, 1'b0, 2'd0);
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        #1;
        check_now("reset_async", mk(1'b1, 1'b0, 2'd0));
        nxt(3);
        release_rst();
    endtask

    // Monitor: every change of the observable outputs must match the queue head.
    always @(negedge clk) begin : mon
        snap_t c;
        ev_t   x;
        c = cur_snap();
        if (c != prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change edge=%0d got pr=%0d sr=%0d st=%0d ll=%0d to=%0d",
                         edge_n, c.pr, c.sr, c.st, c.ll, c.to);
            end else begin
                x = exp_q.pop_front();
                if ((x.e != edge_n) || (x.s != c)) begin
                    bad++;
                    $display("FAIL seq_event got edge=%0d pr=%0d sr=%0d st=%0d ll=%0d to=%0d exp edge=%0d pr=%0d sr=%0d st=%0d ll=%0d to=%0d",
                             edge_n, c.pr, c.sr, c.st, c.ll, c.to,
                             x.e, x.s.pr, x.s.sr, x.s.st, x.s.ll, x.s.to);
                end
            end
            prev = c;
        end
    end

    initial begin
        int a;
        int k;
        reset_n    = 1'b1;
        pll_locked = 1'b0;
        prev       = mk(1'b1, 1'b0, 2'd0);
        #1 reset_n = 1'b0;
        #1 check_now("reset_init", mk(1'b1, 1'b0, 2'd0));
        nxt(3);

        // Nominal release: lock raised 10 cycles after reset deassertion.
        release_rst();
        nxt(10);
        raise_lock();
        nxt(12);

        // Reset mid-RUN, then a one-cycle glitch during STABLE.
        reset_mid();
        nxt(6);
        a = edge_n;
        pll_locked = 1'b1;
        push(a + 3,  1'b0, 1'b0, 2'd2);
        push(a + 8,  1'b0, 1'b0, 2'd1);
        push(a + 9,  1'b0, 1'b0, 2'd2);
        push(a + 17, 1'b0, 1'b1, 2'd3);
        nxt(5);
        pll_locked = 1'b0;
        nxt(1);
        pll_locked = 1'b1;
        nxt(12);

        // Lock loss in RUN followed by relock.
        drop_in_run();
        raise_lock();
        nxt(12);

        // Lock never returns: three timeouts, 36-cycle re-pulse period.
        k = edge_n;
        pll_locked = 1'b0;
        ll_n++;
        push(k + 3, 1'b1, 1'b0, 2'd0);
        push(k + 7, 1'b0, 1'b0, 2'd1);
        for (int t = 1; t <= 3; t++) begin
            to_n = t;
            push(k + 3 + 36 * t, 1'b1, 1'b0, 2'd0);
            push(k + 7 + 36 * t, 1'b0, 1'b0, 2'd1);
        end
        nxt(116);
        raise_lock();
        nxt(12);

        // Many lock losses drive lock_lost_cnt into saturation.
        for (int i = 0; i < 300; i++) begin
            drop_in_run();
            raise_lock();
            nxt(12);
        end

        reset_mid();
        nxt(6);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) nxt(1);
        while (exp_q.size() > 0) begin
            ev_t x;
            x = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got none exp edge=%0d pr=%0d sr=%0d st=%0d",
                     x.e, x.s.pr, x.s.sr, x.s.st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles `pll_rst` is held high per PLL reset pulse (minimum 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before releasing system reset (minimum 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles to wait for lock before re-pulsing `pll_rst` (minimum 1).
REQ-004 Port: `clk`, input, 1 bit: free-running 50 MHz PLL reference clock; sole clock of the block.
REQ-005 Port: `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port: `pll_locked`, input, 1 bit: PLL `locked` output, asynchronous to `clk`.
REQ-007 Port: `pll_rst`, output, 1 bit: active-high drive to the PLL `rst` input.
REQ-008 Port: `sys_reset_n`, output, 1 bit: active-low reset for downstream logic; high only in RUN.
REQ-009 Port: `seq_state`, output, 2 bits: current state (0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN).
REQ-010 Port: `lock_lost_cnt`, output, 8 bits: count of lock losses seen in RUN.
REQ-011 Port: `timeout_cnt`, output, 8 bits: count of WAIT_LOCK timeouts.

Function
REQ-012 `pll_locked` SHALL pass through a 2-flop synchronizer; the result is `locked_s`, and all decisions use `locked_s` only.
REQ-013 PLL_RST: `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then transition to WAIT_LOCK.
REQ-014 WAIT_LOCK transitions:
  - `pll_rst`=0; one shared down-counter counts waiting cycles.
  - `locked_s`=1 -> STABLE.
  - LOCK_TIMEOUT_CYCLES cycles without lock -> PLL_RST, and `timeout_cnt` increments.
REQ-015 STABLE transitions:
  - Counts consecutive `locked_s`=1 cycles.
  - `locked_s`=0 at any point -> WAIT_LOCK with a fresh timeout; no counter increments.
  - Reaching LOCK_STABLE_CYCLES -> RUN.
REQ-016 Release latency: `sys_reset_n` SHALL rise exactly LOCK_STABLE_CYCLES+3 `clk` edges after the first edge that samples `pll_locked`=1, provided lock holds throughout.
REQ-017 RUN: `sys_reset_n`=1 and `pll_rst`=0. On `locked_s`=0, the next edge drives `sys_reset_n`=0, enters PLL_RST, and increments `lock_lost_cnt`.
REQ-018 `lock_lost_cnt` and `timeout_cnt` SHALL saturate at 255 and never wrap.
REQ-019 The internal counter SHALL be sized `$clog2` of the largest parameter plus 1; no parameter value may cause overflow.
REQ-020 `sys_reset_n` and `pll_rst` SHALL be registered outputs with no combinational path from `pll_locked`.
REQ-021 A `locked_s` drop on the same edge that STABLE completes SHALL take the drop path to WAIT_LOCK; RUN is not entered.

Reset
REQ-022 Asserting `reset_n` low SHALL asynchronously force the following, from any state, including mid-pulse or mid-count:
  - state = PLL_RST;
  - `pll_rst`=1;
  - `sys_reset_n`=0;
  - `seq_state`=0;
  - both statistics counters = 0;
  - synchronizer flops = 0.
REQ-023 After `reset_n` deasserts, the first PLL_RST pulse SHALL last the full PLL_RST_CYCLES.

Configuration
REQ-024 Macro PLL_RST_SEQ_STATS_EN defined: `lock_lost_cnt` and `timeout_cnt` are implemented per REQ-014, REQ-017 and REQ-018.
REQ-025 Macro PLL_RST_SEQ_STATS_EN undefined: both counters are tied to constant 0 and consume no flops; all other behaviour is identical.

Verification
REQ-026 Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32; stats enabled unless stated. The bench SHALL cover:
  - Nominal release: deassert `reset_n`, raise `pll_locked` after 10 cycles -> `pll_rst` high exactly 4 cycles; `sys_reset_n` rises 11 edges after `pll_locked` is sampled high; `seq_state`=3.
  - Timeout: hold `pll_locked`=0 -> `pll_rst` re-pulses every 4+32 cycles; `timeout_cnt` reads 1, 2, 3.
  - Glitch in STABLE: `pll_locked` high 5 cycles, low 1, high -> return to WAIT_LOCK; `sys_reset_n` rises 11 edges after the second rise; counters stay 0.
  - Loss in RUN: drop `pll_locked` -> `sys_reset_n`=0 three edges later; `pll_rst` high 4 cycles; `lock_lost_cnt`=1; relock releases again.
  - Saturation and reset: force 300 lock losses -> `lock_lost_cnt`=255; assert `reset_n` mid-RUN -> all outputs at reset values immediately.
  - Build without PLL_RST_SEQ_STATS_EN: repeat the timeout and loss-in-RUN scenarios -> both counters read 0; all timing unchanged.
